// File: rtl/xrq_dispatch_pkg.sv
// Shared NOU request-queue definitions: field widths, rtype encodings, UOV bit indices and entry layout.
package xrq_dispatch_pkg;

  localparam int NOU_SID_WIDTH         = 4;
  localparam int NOU_XOCC_CMD_WIDTH    = 32;
  localparam int NOU_REQ_TYPE_ID_WIDTH = 3;
  localparam int NOU_UOV_SIZE          = 5;
  localparam int NOU_XRQ_ENTRY_W       = 1 + NOU_SID_WIDTH + NOU_XOCC_CMD_WIDTH + NOU_UOV_SIZE;

  localparam logic [NOU_REQ_TYPE_ID_WIDTH-1:0] NOU_RT_GRANT_BUF    = 3'd0;
  localparam logic [NOU_REQ_TYPE_ID_WIDTH-1:0] NOU_RT_GRANT_WL     = 3'd1;
  localparam logic [NOU_REQ_TYPE_ID_WIDTH-1:0] NOU_RT_RECLAIM_BUF  = 3'd2;
  localparam logic [NOU_REQ_TYPE_ID_WIDTH-1:0] NOU_RT_RECLAIM_WL   = 3'd3;
  localparam logic [NOU_REQ_TYPE_ID_WIDTH-1:0] NOU_RT_SEND_PKT_ID  = 3'd4;
  localparam logic [NOU_REQ_TYPE_ID_WIDTH-1:0] NOU_RT_SEND_PKT_REQ = 3'd5;

  localparam int NOU_UOV_IRR   = 0;
  localparam int NOU_UOV_BRR   = 1;
  localparam int NOU_UOV_PWRR  = 2;
  localparam int NOU_UOV_SPIDR = 3;
  localparam int NOU_UOV_SPRR  = 4;

  // What the FIFO actually stores; the valid bit is derived from occupancy at the output.
  typedef struct packed {
    logic [NOU_UOV_SIZE-1:0]       uov;
    logic [NOU_XOCC_CMD_WIDTH-1:0] cmd;
    logic [NOU_SID_WIDTH-1:0]      sid;
  } xrq_slot_t;

  typedef struct packed {
    logic [NOU_UOV_SIZE-1:0]       uov;
    logic [NOU_XOCC_CMD_WIDTH-1:0] cmd;
    logic [NOU_SID_WIDTH-1:0]      sid;
    logic                          vld;
  } xrq_entry_t;

  function automatic logic [NOU_UOV_SIZE-1:0] uov_bit(input int idx);
    uov_bit      = '0;
    uov_bit[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/xrq_dispatch_uov_classify.sv
// Combinational rtype -> one-hot unit-of-validity mask; unknown rtypes go to the invalid-request unit.
module xrq_uov_classify
  import xrq_dispatch_pkg::*;
(
  input  logic [NOU_REQ_TYPE_ID_WIDTH-1:0] rtype,
  output logic [NOU_UOV_SIZE-1:0]          uov
);

  always_comb begin
    uov = uov_bit(NOU_UOV_IRR);
    case (rtype)
      NOU_RT_GRANT_BUF,   NOU_RT_RECLAIM_BUF: uov = uov_bit(NOU_UOV_BRR);
      NOU_RT_GRANT_WL,    NOU_RT_RECLAIM_WL:  uov = uov_bit(NOU_UOV_PWRR);
      NOU_RT_SEND_PKT_ID:                     uov = uov_bit(NOU_UOV_SPIDR);
      NOU_RT_SEND_PKT_REQ:                    uov = uov_bit(NOU_UOV_SPRR);
      default:                                uov = uov_bit(NOU_UOV_IRR);
    endcase
  end

endmodule

// File: rtl/xrq_dispatch.sv
// In-order XOCC request queue: head visible the cycle after push, dispatched when all targeted units are ready.
// Upstream is backpressured only by full; a blocked head stalls everything behind it.
module xrq_dispatch
  import xrq_dispatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          xocc_cmd_vld,
  output logic                          xocc_cmd_rdy,
  input  logic [NOU_SID_WIDTH-1:0]      xocc_sid,
  input  logic [NOU_XOCC_CMD_WIDTH-1:0] xocc_cmd,
  input  logic [NOU_UOV_SIZE-1:0]       unit_rdy,
  output logic [NOU_XRQ_ENTRY_W-1:0]    entry_output,
  output logic                          rd_port_vld,
  output logic [CNT_W-1:0]              xrq_cnt,
  output logic                          xrq_empty,
  output logic                          xrq_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  xrq_slot_t mem_q [DEPTH];
  xrq_slot_t wr_slot;
  xrq_slot_t head;
  xrq_entry_t head_ent;

  logic [NOU_UOV_SIZE-1:0] push_uov;
  logic empty, full, push, pop;

  xrq_uov_classify u_classify (
    .rtype (xocc_cmd[NOU_REQ_TYPE_ID_WIDTH-1:0]),
    .uov   (push_uov)
  );

  // Wrap bit disambiguates full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign head = mem_q[rd_ptr_q[AW-1:0]];
  assign push = xocc_cmd_vld && !full;
  assign pop  = !empty && ((head.uov & unit_rdy) == head.uov);

  always_comb begin
    wr_slot.uov = push_uov;
    wr_slot.cmd = xocc_cmd;
    wr_slot.sid = xocc_sid;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage carries no reset; stale slots are never observable behind the empty gating.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_slot;
    end
  end

  always_comb begin
    head_ent     = '0;
    if (!empty) begin
      head_ent.uov = head.uov;
      head_ent.cmd = head.cmd;
      head_ent.sid = head.sid;
      head_ent.vld = 1'b1;
    end
    entry_output = head_ent;
  end

  assign xocc_cmd_rdy = !full;
  assign rd_port_vld  = pop;
  assign xrq_cnt      = cnt_q;
  assign xrq_empty    = empty;
  assign xrq_full     = full;

endmodule

// File: tb/tb_xrq_dispatch.sv
// Queue-based reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_xrq_dispatch;
  import xrq_dispatch_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int EW    = NOU_XRQ_ENTRY_W;

  logic                          clk = 1'b0;
  logic                          rstn;
  logic                          xocc_cmd_vld;
  logic                          xocc_cmd_rdy;
  logic [NOU_SID_WIDTH-1:0]      xocc_sid;
  logic [NOU_XOCC_CMD_WIDTH-1:0] xocc_cmd;
  logic [NOU_UOV_SIZE-1:0]       unit_rdy;
  logic [EW-1:0]                 entry_output;
  logic                          rd_port_vld;
  logic [CNT_W-1:0]              xrq_cnt;
  logic                          xrq_empty;
  logic                          xrq_full;

  always #5 clk = ~clk;

  xrq_dispatch #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .xocc_cmd_vld (xocc_cmd_vld),
    .xocc_cmd_rdy (xocc_cmd_rdy),
    .xocc_sid     (xocc_sid),
    .xocc_cmd     (xocc_cmd),
    .unit_rdy     (unit_rdy),
    .entry_output (entry_output),
    .rd_port_vld  (rd_port_vld),
    .xrq_cnt      (xrq_cnt),
    .xrq_empty    (xrq_empty),
    .xrq_full     (xrq_full)
  );

  typedef struct {
    logic [NOU_SID_WIDTH-1:0]      sid;
    logic [NOU_XOCC_CMD_WIDTH-1:0] cmd;
  } cmd_t;

  typedef struct {
    logic [EW-1:0] ent;
    int            cyc;
  } disp_t;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  cmd_t  model_q[$];
  disp_t log_q[$];
  logic [4:0] mask_tbl [8];
  logic [4:0] sweep_exp [8];

  function automatic logic [4:0] exp_mask(input logic [NOU_XOCC_CMD_WIDTH-1:0] c);
    return mask_tbl[c[2:0]];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0]  log_mask(input int i); return log_q[i].ent[EW-1 -: 5]; endfunction
  function automatic logic [31:0] log_cmd(input int i);  return log_q[i].ent[1+NOU_SID_WIDTH +: 32]; endfunction
  function automatic logic [3:0]  log_sid(input int i);  return log_q[i].ent[1 +: NOU_SID_WIDTH]; endfunction

  task automatic monitor();
    logic          e_empty, e_full, e_vld, do_push, do_pop;
    logic [4:0]    m;
    logic [EW-1:0] e_ent;
    cmd_t          pc;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) model_q.delete();
      e_empty = (model_q.size() == 0);
      e_full  = (model_q.size() == DEPTH);
      m       = '0;
      e_ent   = '0;
      if (!e_empty) begin
        m     = exp_mask(model_q[0].cmd);
        e_ent = {m, model_q[0].cmd, model_q[0].sid, 1'b1};
      end
      e_vld = !e_empty && ((m & unit_rdy) == m);
      chk("m_rdy",   xocc_cmd_rdy, !e_full);
      chk("m_vld",   rd_port_vld,  e_vld);
      chk("m_entry", entry_output, e_ent);
      chk("m_cnt",   xrq_cnt,      model_q.size());
      chk("m_empty", xrq_empty,    e_empty);
      chk("m_full",  xrq_full,     e_full);
      if (rd_port_vld) log_q.push_back('{entry_output, cyc});
      do_push = rstn && xocc_cmd_vld && !e_full;
      do_pop  = rstn && e_vld;
      pc      = '{xocc_sid, xocc_cmd};
      @(posedge clk);
      if (!rstn) model_q.delete();
      else begin
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(pc);
      end
    end
  endtask

  initial begin
    int acc;
    int c0;
    mask_tbl  = '{5'b00010, 5'b00100, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00001};
    sweep_exp = '{5'b00010, 5'b00100, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00001};
    rstn = 1'b0; xocc_cmd_vld = 1'b0; xocc_sid = '0; xocc_cmd = '0; unit_rdy = '0;
    fork monitor(); join_none

    // Reset state
    step(); step();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_rdy",   xocc_cmd_rdy, 1'b1);
    chk("rst_vld",   rd_port_vld,  1'b0);
    chk("rst_entry", entry_output, '0);
    chk("rst_cnt",   xrq_cnt,      0);
    chk("rst_empty", xrq_empty,    1'b1);
    chk("rst_full",  xrq_full,     1'b0);

    // Single push: rtype 0, sid 3
    step();
    xocc_cmd_vld = 1'b1; xocc_sid = 4'd3; xocc_cmd = 32'hABCD_0010; unit_rdy = 5'h1f;
    step();
    xocc_cmd_vld = 1'b0;
    @(negedge clk);
    chk("t1_vld",  rd_port_vld, 1'b1);
    chk("t1_mask", entry_output[EW-1 -: 5], 5'b00010);
    chk("t1_sid",  entry_output[1 +: NOU_SID_WIDTH], 4'd3);
    chk("t1_bit0", entry_output[0], 1'b1);
    chk("t1_cnt1", xrq_cnt, 1);
    @(negedge clk);
    chk("t1_cnt0", xrq_cnt, 0);

    // Classification sweep
    step();
    log_q.delete();
    for (int i = 0; i < 8; i++) begin
      xocc_cmd_vld = 1'b1; xocc_sid = 4'(i); xocc_cmd = 32'h0002_0000 | 32'(i);
      step();
    end
    xocc_cmd_vld = 1'b0;
    repeat (10) step();
    chk("t2_count", log_q.size(), 8);
    if (log_q.size() == 8) begin
      c0 = log_q[0].cyc;
      for (int i = 0; i < 8; i++) begin
        chk("t2_mask",  log_mask(i), sweep_exp[i]);
        chk("t2_order", log_cmd(i), 32'h0002_0000 | 32'(i));
        chk("t2_cyc",   log_q[i].cyc, c0 + i);
      end
    end

    // Fill while blocked, then drain
    unit_rdy = '0;
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      xocc_cmd_vld = 1'b1; xocc_sid = 4'(i); xocc_cmd = {16'h0003, 8'(i), 8'(i % 8)};
      if (xocc_cmd_rdy) acc++;
      step();
    end
    xocc_cmd_vld = 1'b0;
    @(negedge clk);
    chk("t3_accepted", acc, DEPTH);
    chk("t3_full",     xrq_full, 1'b1);
    chk("t3_rdy",      xocc_cmd_rdy, 1'b0);
    chk("t3_cnt",      xrq_cnt, DEPTH);
    step();
    log_q.delete();
    unit_rdy = 5'h1f;
    repeat (DEPTH + 3) step();
    chk("t3_drained", log_q.size(), DEPTH);
    if (log_q.size() == DEPTH) begin
      c0 = log_q[0].cyc;
      for (int i = 0; i < DEPTH; i++) begin
        chk("t3_order", log_cmd(i), {16'h0003, 8'(i), 8'(i % 8)});
        chk("t3_cyc",   log_q[i].cyc, c0 + i);
      end
    end

    // Head-of-line blocking
    unit_rdy = 5'b00010;
    log_q.delete();
    xocc_cmd_vld = 1'b1; xocc_sid = 4'd1; xocc_cmd = 32'h0004_0004;
    step();
    xocc_sid = 4'd2; xocc_cmd = 32'h0004_0000;
    step();
    xocc_cmd_vld = 1'b0;
    repeat (4) step();
    chk("t4_blocked", log_q.size(), 0);
    unit_rdy = 5'b01010;
    repeat (4) step();
    chk("t4_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t4_first",  log_mask(0), 5'b01000);
      chk("t4_second", log_mask(1), 5'b00010);
      chk("t4_cyc",    log_q[1].cyc, log_q[0].cyc + 1);
    end

    // Steady push+pop at occupancy 3 across pointer wraps
    unit_rdy = '0;
    log_q.delete();
    for (int k = 0; k < 3 + 3 * DEPTH; k++) begin
      if (k == 3) unit_rdy = 5'h1f;
      xocc_cmd_vld = 1'b1; xocc_sid = 4'(k); xocc_cmd = {16'h0005, 8'(k), 8'(k % 8)};
      if (k >= 3) begin
        @(negedge clk);
        chk("t5_cnt", xrq_cnt, 3);
      end
      step();
    end
    xocc_cmd_vld = 1'b0;
    repeat (6) step();
    chk("t5_count", log_q.size(), 3 + 3 * DEPTH);
    if (log_q.size() == 3 + 3 * DEPTH)
      for (int k = 0; k < 3 + 3 * DEPTH; k++)
        chk("t5_order", log_cmd(k), {16'h0005, 8'(k), 8'(k % 8)});

    // Asynchronous reset with entries in flight
    unit_rdy = '0;
    for (int k = 0; k < 5; k++) begin
      xocc_cmd_vld = 1'b1; xocc_sid = 4'(k); xocc_cmd = 32'h0006_0000 | 32'(k);
      step();
    end
    xocc_cmd_vld = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rdy",   xocc_cmd_rdy, 1'b1);
    chk("t6_vld",   rd_port_vld,  1'b0);
    chk("t6_entry", entry_output, '0);
    chk("t6_cnt",   xrq_cnt,      0);
    chk("t6_empty", xrq_empty,    1'b1);
    chk("t6_full",  xrq_full,     1'b0);
    step(); step();
    rstn = 1'b1;
    log_q.delete();
    unit_rdy = 5'h1f;
    xocc_cmd_vld = 1'b1; xocc_sid = 4'd9; xocc_cmd = 32'h0006_5A00;
    step();
    xocc_cmd_vld = 1'b0;
    repeat (3) step();
    chk("t6_count", log_q.size(), 1);
    if (log_q.size() == 1) begin
      chk("t6_cmd", log_cmd(0), 32'h0006_5A00);
      chk("t6_sid", log_sid(0), 4'd9);
    end

    // Randomized traffic against the model
    repeat (3000) begin
      xocc_cmd_vld = ($urandom_range(0, 99) < 60);
      xocc_sid     = 4'($urandom);
      xocc_cmd     = $urandom;
      unit_rdy     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1f;
      step();
    end
    xocc_cmd_vld = 1'b0;
    unit_rdy = 5'h1f;
    repeat (DEPTH + 2) step();
    @(negedge clk);
    chk("rnd_drained", xrq_empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
